// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin arbiter feeding general_dec.
// Picks one of N = 2**INPUT_WIDTH requesters and drives the decoder's binary
// select (w) and enable (en). A grant is held until the owner pulses done or
// drops its request, and is always followed by at least one idle cycle. The
// search for the next owner starts just after the previous one, so priority
// rotates.
// Optional feature: define RR_TIMEOUT_EN to cap a grant at MAX_HOLD cycles.
module rr_grant_encoder #(
  parameter int INPUT_WIDTH = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2**INPUT_WIDTH-1:0]   req,
  input  logic                        done,
  output logic [INPUT_WIDTH-1:0]      w,
  output logic                        en
);

  localparam int N = 2**INPUT_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The hold counter is 8 bits wide, so the cap must fit in it.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_grant_encoder: MAX_HOLD must be in 1..255");
  end

  state_t                 state, state_nxt;
  logic [INPUT_WIDTH-1:0] ptr, ptr_nxt;
  logic [INPUT_WIDTH-1:0] w_nxt;
  logic [INPUT_WIDTH-1:0] pick;
  logic [INPUT_WIDTH-1:0] cand;
  logic                   found;
  logic                   timeout;
  logic                   release_grant;

`ifdef RR_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Count cycles spent in GRANT; the count sits at zero while idle so it is
  // already cleared on the edge that enters GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (state == IDLE) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  // During the MAX_HOLD-th grant cycle the count is MAX_HOLD-1, so releasing
  // at the end of that cycle keeps en high for exactly MAX_HOLD cycles.
  assign timeout = (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign timeout = 1'b0;
`endif

  // The owner lets go when it says so, stops requesting, or runs out of time.
  assign release_grant = done || !req[w] || timeout;

  // Circular search for the first requester after ptr; i == N wraps back to
  // ptr itself, so the last owner is considered only after everyone else.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    pick  = ptr;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = ptr + INPUT_WIDTH'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state logic: arbitrate only from IDLE, release only from GRANT.
  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          w_nxt     = pick;
          ptr_nxt   = pick;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, select and priority pointer registers. ptr resets to N-1 so the
  // very first search begins at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all registers here are small control flops, so every one of them is reset.
    if (!rst_n) begin
      state <= IDLE;
      w     <= '0;
      ptr   <= INPUT_WIDTH'(N - 1);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      w     <= w_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // en is a direct decode of the state flop, so it is registered and drops
  // with the asynchronous reset.
  assign en = (state == GRANT);

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Testbench for rr_grant_encoder (INPUT_WIDTH=2, N=4, MAX_HOLD=4).
// Table-driven vectors cover arbitration, hold, release and rotation; short
// hand-written sequences cover reset behaviour and the grant-length cap.
module tb_rr_grant_encoder;

  localparam int IW       = 2;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          done;
  logic [IW-1:0] w;
  logic          en;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic [N-1:0]  req;
    logic          done;
    logic [IW-1:0] exp_w;
    logic          exp_en;
  } vec_t;

  vec_t vecs[$];

  rr_grant_encoder #(
    .INPUT_WIDTH (IW),
    .MAX_HOLD    (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .w     (w),
    .en    (en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse spanning one edge, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n = 1'b1;
    req   = '0;
    done  = 1'b0;

    // Round robin, done ignored in IDLE, hold, simultaneous done+req,
    // requester drop and wrap-around priority.
    vecs.push_back('{4'b1111, 1'b0, 2'd0, 1'b1});
    vecs.push_back('{4'b1111, 1'b1, 2'd0, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 2'd1, 1'b1});
    vecs.push_back('{4'b1111, 1'b1, 2'd1, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 2'd2, 1'b1});
    vecs.push_back('{4'b1111, 1'b1, 2'd2, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 2'd3, 1'b1});
    vecs.push_back('{4'b1111, 1'b1, 2'd3, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 2'd0, 1'b1});
    vecs.push_back('{4'b1111, 1'b1, 2'd0, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 2'd0, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 2'd1, 1'b1});
    vecs.push_back('{4'b1010, 1'b0, 2'd1, 1'b1});
    vecs.push_back('{4'b1111, 1'b1, 2'd1, 1'b0});
    vecs.push_back('{4'b1100, 1'b0, 2'd2, 1'b1});
    vecs.push_back('{4'b0000, 1'b0, 2'd2, 1'b0});
    vecs.push_back('{4'b0010, 1'b0, 2'd1, 1'b1});
    vecs.push_back('{4'b0000, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 2'd1, 1'b0});
    vecs.push_back('{4'b1000, 1'b0, 2'd3, 1'b1});
    vecs.push_back('{4'b1000, 1'b1, 2'd3, 1'b0});
    vecs.push_back('{4'b1001, 1'b0, 2'd0, 1'b1});
    vecs.push_back('{4'b1001, 1'b1, 2'd0, 1'b0});
    vecs.push_back('{4'b1001, 1'b0, 2'd3, 1'b1});
    vecs.push_back('{4'b1001, 1'b1, 2'd3, 1'b0});

    // Reset held with all requests pending: nothing granted.
    rst_n = 1'b0;
    req   = 4'b1111;
    #2;
    step();
    check("reset_w", 32'(w), 32'd0);
    check("reset_en", 32'(en), 32'd0);
    step();
    check("reset_hold_en", 32'(en), 32'd0);

    // First grant after reset goes straight to the lone requester.
    rst_n = 1'b1;
    req   = 4'b0100;
    step();
    check("first_grant_w", 32'(w), 32'd2);
    check("first_grant_en", 32'(en), 32'd1);

    // Table of vectors from a fresh reset.
    do_reset();
    foreach (vecs[i]) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      check($sformatf("vec%0d_w", i), 32'(w), 32'(vecs[i].exp_w));
      check($sformatf("vec%0d_en", i), 32'(en), 32'(vecs[i].exp_en));
    end
    done = 1'b0;

    // Asynchronous reset between clock edges during a grant.
    do_reset();
    req = 4'b0100;
    step();
    check("pre_async_w", 32'(w), 32'd2);
    check("pre_async_en", 32'(en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_en", 32'(en), 32'd0);
    check("async_rst_w", 32'(w), 32'd0);
    #1;
    rst_n = 1'b1;
    req   = 4'b0101;
    step();
    check("post_async_w", 32'(w), 32'd0);
    check("post_async_en", 32'(en), 32'd1);

    // Grant length with a requester that never lets go.
    do_reset();
    req  = 4'b0011;
    done = 1'b0;
`ifdef RR_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("timeout%0d_en", k), 32'(en), ((k % 5) < 4) ? 32'd1 : 32'd0);
      check($sformatf("timeout%0d_w", k), 32'(w), (((k / 5) % 2) == 0) ? 32'd0 : 32'd1);
    end
`else
    for (int k = 0; k < 2 * MAX_HOLD; k++) begin
      step();
      check($sformatf("nocap%0d_en", k), 32'(en), 32'd1);
      check($sformatf("nocap%0d_w", k), 32'(w), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
